axil2avm_master_bridge: RTL

- AXI4-Lite slave to Avalon-MM master bridge. It lets the PicoRV32 AXI-Lite bus initiate reads and writes to the Qsys on-chip memory and other Avalon-MM slaves.
- One transaction is in flight at a time. Avalon slaves have a fixed read latency and optional waitrequest.
- The bridge sits between the CPU AXI-Lite port and the Qsys memory slave port (32-bit data, word address, byteenable).

---
 rtl/axil2avm_master_bridge.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axil2avm_master_bridge.sv
// AXI4-Lite slave to Avalon-MM master bridge, one transaction in flight.
// Arbitrates read vs write round-robin and decodes a single aligned address window.
//
// state    | meaning
// IDLE     | ready raised for the granted channel, waiting for a handshake
// WCOLLECT | one of AW/W latched, waiting for the other
// WBUS     | Avalon write issued, held through waitrequest, then one idle cycle
// WRESP    | bvalid held until bready
// RBUS     | Avalon read issued, held through waitrequest
// RWAIT    | counting down the fixed read latency
// RRESP    | rvalid held with stable rdata/rresp until rready
module axil2avm_master_bridge #(
    parameter int          AVM_AW       = 12,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [31:0]       s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic [AVM_AW-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_read,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);
    typedef enum logic [2:0] {IDLE, WCOLLECT, WBUS, WRESP, RBUS, RWAIT, RRESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t              state_q, state_d;
    logic                awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [AVM_AW-1:0]   address_q, address_d;
    logic [3:0]          be_q, be_d;
    logic                cs_q, cs_d, write_q, write_d, read_q, read_d;
    logic [31:0]         writedata_q, writedata_d;
    logic                aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [31:2]         awaddr_q, awaddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [1:0]          lat_cnt_q, lat_cnt_d;
    logic                last_wr_q, last_wr_d;

    logic        aw_hs, w_hs, ar_hs, write_both, launch_wr;
    logic [31:2] aw_addr_n;
    logic [31:0] w_data_n;
    logic [3:0]  w_strb_n;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    function automatic logic addr_hit(input logic [31:2] a);
        return a[31:AVM_AW+2] == BASE_ADDR[31:AVM_AW+2];
    endfunction

    always_comb begin
        state_d     = state_q;
        awready_d   = 1'b0;
        wready_d    = 1'b0;
        arready_d   = 1'b0;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        address_d   = address_q;
        be_d        = be_q;
        cs_d        = cs_q;
        write_d     = write_q;
        read_d      = read_q;
        writedata_d = writedata_q;
        aw_got_d    = aw_got_q;
        w_got_d     = w_got_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        lat_cnt_d   = lat_cnt_q;
        last_wr_d   = last_wr_q;
        launch_wr   = 1'b0;

        aw_hs      = s_awvalid & awready_q;
        w_hs       = s_wvalid & wready_q;
        ar_hs      = s_arvalid & arready_q;
        aw_addr_n  = aw_hs ? s_awaddr[31:2] : awaddr_q;
        w_data_n   = w_hs ? s_wdata : wdata_q;
        w_strb_n   = w_hs ? s_wstrb : wstrb_q;
        write_both = (aw_got_q | aw_hs) & (w_got_q | w_hs);

        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    last_wr_d = 1'b0;
                    if (addr_hit(s_araddr[31:2])) begin
                        state_d   = RBUS;
                        cs_d      = 1'b1;
                        read_d    = 1'b1;
                        address_d = s_araddr[AVM_AW+1:2];
                        be_d      = 4'hF;
                    end else begin
                        state_d  = RRESP;
                        rvalid_d = 1'b1;
                        rdata_d  = 32'h0;
                        rresp_d  = RESP_SLVERR;
                    end
                end else if (aw_hs | w_hs) begin
                    last_wr_d = 1'b1;
                    awaddr_d  = aw_addr_n;
                    wdata_d   = w_data_n;
                    wstrb_d   = w_strb_n;
                    if (write_both) begin
                        launch_wr = 1'b1;
                    end else begin
                        state_d   = WCOLLECT;
                        aw_got_d  = aw_hs;
                        w_got_d   = w_hs;
                        awready_d = !aw_hs;
                        wready_d  = !w_hs;
                    end
                end else if ((s_awvalid | s_wvalid) & (!s_arvalid | !last_wr_q)) begin
                    // Readies are registered, so grant one side a cycle ahead.
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end else if (s_arvalid) begin
                    arready_d = 1'b1;
                end
            end
            WCOLLECT: begin
                aw_got_d = aw_got_q | aw_hs;
                w_got_d  = w_got_q | w_hs;
                awaddr_d = aw_addr_n;
                wdata_d  = w_data_n;
                wstrb_d  = w_strb_n;
                if (write_both) begin
                    launch_wr = 1'b1;
                end else begin
                    awready_d = !aw_got_d;
                    wready_d  = !w_got_d;
                end
            end
            WBUS: begin
                if (write_q) begin
                    if (!avm_waitrequest) begin
                        cs_d    = 1'b0;
                        write_d = 1'b0;
                    end
                end else begin
                    state_d  = WRESP;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_OKAY;
                end
            end
            WRESP: begin
                if (s_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RBUS: begin
                if (!avm_waitrequest) begin
                    cs_d      = 1'b0;
                    read_d    = 1'b0;
                    lat_cnt_d = 2'(READ_LATENCY);
                    state_d   = RWAIT;
                end
            end
            RWAIT: begin
                if (lat_cnt_q == 2'd1) begin
                    rdata_d  = avm_readdata;
                    rresp_d  = RESP_OKAY;
                    rvalid_d = 1'b1;
                    state_d  = RRESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            RRESP: begin
                if (s_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch_wr) begin
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
            if (addr_hit(aw_addr_n)) begin
                state_d     = WBUS;
                cs_d        = 1'b1;
                write_d     = 1'b1;
                address_d   = aw_addr_n[AVM_AW+1:2];
                be_d        = w_strb_n;
                writedata_d = w_data_n;
            end else begin
                state_d  = WRESP;
                bvalid_d = 1'b1;
                bresp_d  = RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= 32'h0;
            address_q   <= '0;
            be_q        <= 4'h0;
            cs_q        <= 1'b0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            writedata_q <= 32'h0;
            aw_got_q    <= 1'b0;
            w_got_q     <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            lat_cnt_q   <= 2'd0;
            last_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            arready_q   <= arready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            address_q   <= address_d;
            be_q        <= be_d;
            cs_q        <= cs_d;
            write_q     <= write_d;
            read_q      <= read_d;
            writedata_q <= writedata_d;
            aw_got_q    <= aw_got_d;
            w_got_q     <= w_got_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            lat_cnt_q   <= lat_cnt_d;
            last_wr_q   <= last_wr_d;
        end
    end

    assign s_awready      = awready_q;
    assign s_wready       = wready_q;
    assign s_arready      = arready_q;
    assign s_bvalid       = bvalid_q;
    assign s_bresp        = bresp_q;
    assign s_rvalid       = rvalid_q;
    assign s_rresp        = rresp_q;
    assign s_rdata        = rdata_q;
    assign avm_address    = address_q;
    assign avm_byteenable = be_q;
    assign avm_chipselect = cs_q;
    assign avm_write      = write_q;
    assign avm_read       = read_q;
    assign avm_writedata  = writedata_q;
endmodule
